wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Writeback stage directly upstream of the register file. Arbitrates results from the single-cycle ALU port and the long-latency port (memory/FPU) onto the single regfile write pair ard/drd.
- Keeps a per-register busy scoreboard so issue logic can detect RAW and WAW hazards.
- Register 0 is never marked busy and never written. ard = 0 means "no write this cycle".

Parameters:
- NUM_REGS, 64, number of architectural registers tracked
- ADDR_W, `LEN_REG_ADDR (6), register address width
- WORD_W, `LEN_WORD (32), data word width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- iss_valid  in  1  issue stage allocating destination iss_rd
- iss_rd  in  ADDR_W  destination register of issuing instruction
- iss_ready  out  1  allocation accepted this cycle
- q_rs1  in  ADDR_W  hazard query address 1
- q_rs2  in  ADDR_W  hazard query address 2
- rs1_busy  out  1  q_rs1 has a pending write
- rs2_busy  out  1  q_rs2 has a pending write
- alu_valid  in  1  ALU result present
- alu_rd  in  ADDR_W  ALU result destination
- alu_data  in  WORD_W  ALU result
- alu_ready  out  1  ALU result accepted
- lng_valid  in  1  long-latency result present
- lng_rd  in  ADDR_W  long-latency result destination
- lng_data  in  WORD_W  long-latency result
- lng_ready  out  1  long-latency result accepted
- ard  out  ADDR_W  regfile write address (registered)
- drd  out  WORD_W  regfile write data (registered)
- wb_err  out  1  sticky: a result was accepted for a non-busy nonzero register

Behaviour:
- Reset (rstn = 0 at posedge): busy[] all 0, ard = 0, drd = 0, wb_err = 0, round-robin pointer = ALU. Reset overrides any in-flight handshake; pending results are dropped.
- Handshakes: a result is transferred when valid && ready at a posedge. ready is combinational from valid, the other port's valid and the pointer; ready does not depend on its own valid.
- Arbitration:
  - Only one result is accepted per cycle.
  - If only one port is valid, that port gets ready = 1.
  - If both are valid, the port the pointer selects wins.
  - After a contested grant the pointer moves to the other port. An uncontested grant leaves the pointer unchanged.
  - With both ports continuously valid, grants alternate ALU, LNG, ALU, ...
- Writeback timing: a result accepted at edge N drives ard/drd during cycle N+1. The regfile commits it at edge N+2. If no result is accepted, ard = 0 at the next edge; drd holds its previous value.
- Scoreboard:
  - busy[r] sets at the edge where iss_valid && iss_ready && r == iss_rd && r != 0.
  - busy[r] clears at the edge that ends the cycle in which ard == r, i.e. together with the regfile commit.
  - busy[0] is always 0.
- Issue:
  - iss_ready = 1 when iss_rd == 0 or busy[iss_rd] == 0. Without the optional feature there is no other condition.
  - Issue allocation is independent of result arbitration; both can happen in the same cycle.
- Simultaneous set and clear of the same register at one edge (possible only with the optional feature): set wins, busy stays 1.
- Hazard query: rsN_busy = busy[q_rsN] combinationally, 0 for address 0.
- Results for rd = 0 are accepted normally and produce ard = 0, so no write occurs.
- A result for a nonzero non-busy register is still written and sets wb_err. wb_err clears only on reset.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined:
  - rsN_busy is 0 when q_rsN == ard && ard != 0, because the value is on drd this cycle.
  - Extra outputs byp1_hit / byp2_hit (1 bit each) flag these cases so the read stage takes drd instead of regfile data.
  - iss_ready is also 1 when iss_rd == ard, re-allocating a register on its writeback cycle; set-wins applies.
- Undefined: the hazard outputs reflect busy[] only, and the byp ports are absent.

Test Plan:
- Reset, then issue rd = 5, then ALU result rd = 5, data 0xDEADBEEF:
  - rs1_busy (q_rs1 = 5) is 1 from the cycle after issue.
  - ard = 5 and drd = 0xDEADBEEF one cycle after acceptance.
  - busy[5] reads 0 the cycle after that.
- Issue rd = 7, hold iss_valid with rd = 7 again -> iss_ready = 0 until 7's writeback commits; then 1 (one cycle earlier with WB_BYPASS_EN).
- Both ports valid continuously for 4 cycles (ALU rd 1..4, LNG rd 9..12, all busy) -> accepts in order ALU1, LNG9, ALU2, LNG10; ard sequence 1, 9, 2, 10; wb_err = 0.
- ALU result rd = 0, data 0x1234 -> alu_ready = 1, ard = 0 next cycle, no busy change, wb_err = 0.
- LNG result for non-busy rd = 3 -> written (ard = 3) and wb_err = 1 sticky; rstn low for one cycle mid-stream -> ard = 0, drd = 0, all busy 0, wb_err = 0.
- WB_BYPASS_EN: q_rs2 = 8 while ard = 8 -> byp2_hit = 1 and rs2_busy = 0; issue rd = 8 in the same cycle -> busy[8] = 1 afterwards.

Source files
------------

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: writeback stage feeding the register file write pair.
// Arbitrates between the single-cycle ALU result port and the long-latency
// result port (round-robin when both are valid), registers the winner onto
// ard/drd, and keeps a per-register busy scoreboard for issue-side RAW/WAW
// hazard detection. Register 0 is never busy and never written.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   iss_valid/iss_rd/iss_ready  destination allocation handshake
//   q_rs1/q_rs2, rs1_busy/rs2_busy  combinational hazard queries
//   alu_valid/alu_rd/alu_data/alu_ready  ALU result handshake
//   lng_valid/lng_rd/lng_data/lng_ready  long-latency result handshake
//   ard/drd                   registered regfile write address/data (ard = 0: no write)
//   wb_err                    sticky: result accepted for a non-busy nonzero register
//
// Optional feature macro: WB_BYPASS_EN
//   Adds byp1_hit/byp2_hit, masks hazards for the register currently on ard,
//   and lets a register be re-allocated in its own writeback cycle.

`ifndef LEN_REG_ADDR
`define LEN_REG_ADDR 6
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module wb_scoreboard #(
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned ADDR_W   = `LEN_REG_ADDR,
  parameter int unsigned WORD_W   = `LEN_WORD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
`ifdef WB_BYPASS_EN
  output logic              byp1_hit,
  output logic              byp2_hit,
`endif
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WORD_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lng_valid,
  input  logic [ADDR_W-1:0] lng_rd,
  input  logic [WORD_W-1:0] lng_data,
  output logic              lng_ready,
  output logic [ADDR_W-1:0] ard,
  output logic [WORD_W-1:0] drd,
  output logic              wb_err
);

  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W-1:0]   r_ard;
  logic [WORD_W-1:0]   r_drd;
  logic                r_err;
  // 0: ALU wins the next contested cycle, 1: LNG wins it.
  logic                r_ptr_lng;

  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_alu_acc;
  logic                w_lng_acc;
  logic                w_acc;
  logic [ADDR_W-1:0]   w_acc_rd;
  logic [WORD_W-1:0]   w_acc_data;
  logic                w_err_set;
  logic                w_rs1_raw;
  logic                w_rs2_raw;
  logic                w_iss_free;

  // Ready depends only on the other port's valid and the pointer, so the two
  // grants can never both fire in one cycle.
  assign alu_ready = !lng_valid || !r_ptr_lng;
  assign lng_ready = !alu_valid || r_ptr_lng;

  assign w_alu_acc  = alu_valid && alu_ready;
  assign w_lng_acc  = lng_valid && lng_ready;
  assign w_acc      = w_alu_acc || w_lng_acc;
  assign w_acc_rd   = w_alu_acc ? alu_rd : lng_rd;
  assign w_acc_data = w_alu_acc ? alu_data : lng_data;
  assign w_err_set  = w_acc && (w_acc_rd != '0) && !r_busy[w_acc_rd];

  assign w_rs1_raw  = (q_rs1 != '0) && r_busy[q_rs1];
  assign w_rs2_raw  = (q_rs2 != '0) && r_busy[q_rs2];
  assign w_iss_free = (iss_rd == '0) || !r_busy[iss_rd];

`ifdef WB_BYPASS_EN
  // The register on ard has its value on drd right now; the read stage
  // forwards it, so it no longer counts as a hazard.
  assign byp1_hit  = (q_rs1 == r_ard) && (r_ard != '0);
  assign byp2_hit  = (q_rs2 == r_ard) && (r_ard != '0);
  assign rs1_busy  = w_rs1_raw && !byp1_hit;
  assign rs2_busy  = w_rs2_raw && !byp2_hit;
  assign iss_ready = w_iss_free || (iss_rd == r_ard);
`else
  assign rs1_busy  = w_rs1_raw;
  assign rs2_busy  = w_rs2_raw;
  assign iss_ready = w_iss_free;
`endif

  // Clear on commit first, then set on allocation, so set wins on a collision.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_ard != '0) begin
      w_busy_nxt[r_ard] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy    <= '0;
      r_ard     <= '0;
      r_drd     <= '0;
      r_err     <= 1'b0;
      r_ptr_lng <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_acc) begin
        r_ard <= w_acc_rd;
        r_drd <= w_acc_data;
      end else begin
        r_ard <= '0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      // Both valid means a grant always happens, so the turn passes over.
      if (alu_valid && lng_valid) begin
        r_ptr_lng <= !r_ptr_lng;
      end
    end
  end

  assign ard    = r_ard;
  assign drd    = r_drd;
  assign wb_err = r_err;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_wb_scoreboard;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        iss_valid;
  logic [5:0]  iss_rd;
  logic        iss_ready;
  logic [5:0]  q_rs1;
  logic [5:0]  q_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        alu_valid;
  logic [5:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lng_valid;
  logic [5:0]  lng_rd;
  logic [31:0] lng_data;
  logic        lng_ready;
  logic [5:0]  ard;
  logic [31:0] drd;
  logic        wb_err;
`ifdef WB_BYPASS_EN
  logic        byp1_hit;
  logic        byp2_hit;
`endif

  wb_scoreboard dut (
    .clk       (clk),
    .rstn      (rstn),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
`ifdef WB_BYPASS_EN
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
`endif
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lng_valid (lng_valid),
    .lng_rd    (lng_rd),
    .lng_data  (lng_data),
    .lng_ready (lng_ready),
    .ard       (ard),
    .drd       (drd),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: set of busy registers, the write in flight, error flag,
  // and who won the most recent contested cycle.
  bit [63:0]   m_busy;
  logic [5:0]  m_ard;
  logic [31:0] m_drd;
  bit          m_err;
  bit          m_last_lng;

  typedef struct {
    bit iv; bit [5:0] ir; bit [5:0] q1; bit [5:0] q2;
    bit av; bit [5:0] ar; bit [31:0] ad;
    bit lv; bit [5:0] lr; bit [31:0] ld;
    bit e_iss; bit e_alu; bit e_lng; bit e_rs1; bit e_rs2;
    bit [5:0] e_ard; bit [31:0] e_drd; bit e_err;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(int iv, int ir, int q1, int q2, int av, int ar, logic [31:0] ad,
                              int lv, int lr, logic [31:0] ld, int e_iss, int e_alu, int e_lng,
                              int e_rs1, int e_rs2, int e_ard, logic [31:0] e_drd, int e_err);
    vec_t v;
    v.iv = 1'(iv); v.ir = 6'(ir); v.q1 = 6'(q1); v.q2 = 6'(q2);
    v.av = 1'(av); v.ar = 6'(ar); v.ad = ad;
    v.lv = 1'(lv); v.lr = 6'(lr); v.ld = ld;
    v.e_iss = 1'(e_iss); v.e_alu = 1'(e_alu); v.e_lng = 1'(e_lng);
    v.e_rs1 = 1'(e_rs1); v.e_rs2 = 1'(e_rs2);
    v.e_ard = 6'(e_ard); v.e_drd = e_drd; v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_ard = '0; m_drd = '0; m_err = 1'b0; m_last_lng = 1'b1;
  endtask

  task automatic drive(input int iv, input int ir, input int q1, input int q2,
                       input int av, input int ar, input logic [31:0] ad,
                       input int lv, input int lr, input logic [31:0] ld);
    iss_valid = 1'(iv); iss_rd = 6'(ir); q_rs1 = 6'(q1); q_rs2 = 6'(q2);
    alu_valid = 1'(av); alu_rd = 6'(ar); alu_data = ad;
    lng_valid = 1'(lv); lng_rd = 6'(lr); lng_data = ld;
  endtask

  // One clock cycle: check combinational outputs against the model (and the
  // vector if use_v), clock, advance the model, check registered outputs.
  task automatic tick(input string tag, input bit use_v, input vec_t v);
    bit e_alu, e_lng, e_iss, e_r1, e_r2, acc_alu, acc_lng;
    logic [5:0] rd;
    logic [31:0] data;
    #1;
    // Contested winner alternates; an uncontested port is always ready.
    e_alu = lng_valid ? m_last_lng : 1'b1;
    e_lng = alu_valid ? !m_last_lng : 1'b1;
    e_iss = (iss_rd == 0) || !m_busy[iss_rd] || (BYP && iss_rd == m_ard);
    e_r1  = (q_rs1 != 0) && m_busy[q_rs1] && !(BYP && q_rs1 == m_ard);
    e_r2  = (q_rs2 != 0) && m_busy[q_rs2] && !(BYP && q_rs2 == m_ard);
    chk({tag, "_alu_ready"}, 32'(alu_ready), 32'(e_alu));
    chk({tag, "_lng_ready"}, 32'(lng_ready), 32'(e_lng));
    chk({tag, "_iss_ready"}, 32'(iss_ready), 32'(e_iss));
    chk({tag, "_rs1_busy"}, 32'(rs1_busy), 32'(e_r1));
    chk({tag, "_rs2_busy"}, 32'(rs2_busy), 32'(e_r2));
`ifdef WB_BYPASS_EN
    chk({tag, "_byp1"}, 32'(byp1_hit), 32'(q_rs1 == m_ard && m_ard != 0));
    chk({tag, "_byp2"}, 32'(byp2_hit), 32'(q_rs2 == m_ard && m_ard != 0));
`endif
    if (use_v) begin
      chk({tag, "_v_alu_ready"}, 32'(alu_ready), 32'(v.e_alu));
      chk({tag, "_v_lng_ready"}, 32'(lng_ready), 32'(v.e_lng));
      chk({tag, "_v_iss_ready"}, 32'(iss_ready), 32'(v.e_iss));
      chk({tag, "_v_rs1_busy"}, 32'(rs1_busy), 32'(v.e_rs1));
      chk({tag, "_v_rs2_busy"}, 32'(rs2_busy), 32'(v.e_rs2));
    end
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      acc_alu = alu_valid && e_alu;
      acc_lng = lng_valid && e_lng;
      rd   = acc_alu ? alu_rd : lng_rd;
      data = acc_alu ? alu_data : lng_data;
      if ((acc_alu || acc_lng) && rd != 0 && !m_busy[rd]) m_err = 1'b1;
      if (m_ard != 0) m_busy[m_ard] = 1'b0;
      if (iss_valid && e_iss && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (alu_valid && lng_valid) m_last_lng = acc_lng;
      m_ard = (acc_alu || acc_lng) ? rd : 6'd0;
      if (acc_alu || acc_lng) m_drd = data;
    end
    #1;
    chk({tag, "_ard"}, 32'(ard), 32'(m_ard));
    chk({tag, "_drd"}, drd, m_drd);
    chk({tag, "_wb_err"}, 32'(wb_err), 32'(m_err));
    if (use_v) begin
      chk({tag, "_v_ard"}, 32'(ard), 32'(v.e_ard));
      chk({tag, "_v_drd"}, drd, v.e_drd);
      chk({tag, "_v_wb_err"}, 32'(wb_err), 32'(v.e_err));
    end
  endtask

  function automatic int pick_rd();
    int start = int'($urandom_range(11, 0));
    if ($urandom_range(99, 0) < 85) begin
      for (int i = 0; i < 12; i++) begin
        if (m_busy[(start + i) % 12]) return (start + i) % 12;
      end
    end
    return start;
  endfunction

  vec_t nov;

  initial begin
    nov = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // iv ir q1 q2 | av ar ad | lv lr ld | iss alu lng rs1 rs2 | ard drd err
    vecs[0]  = mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 5, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 1, 0, 5, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'hDEADBEEF, 0);
    vecs[3]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'hDEADBEEF, 0);
    vecs[4]  = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 32'hDEADBEEF, 0);
    vecs[5]  = mk(1, 9, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 32'hDEADBEEF, 0);
    vecs[6]  = mk(1, 10, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 32'hDEADBEEF, 0);
    // Both ports valid for four cycles: ALU1, LNG9, ALU2, LNG10.
    vecs[7]  = mk(0, 10, 10, 9, 1, 1, 32'h11, 1, 9, 32'h99, 0, 1, 0, 1, 1, 1, 32'h11, 0);
    vecs[8]  = mk(0, 0, 0, 2, 1, 2, 32'h22, 1, 9, 32'h99, 1, 0, 1, 0, 1, 9, 32'h99, 0);
    vecs[9]  = mk(0, 0, 10, 0, 1, 2, 32'h22, 1, 10, 32'hAA, 1, 1, 0, 1, 0, 2, 32'h22, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 3, 32'h33, 1, 10, 32'hAA, 1, 0, 1, 0, 0, 10, 32'hAA, 0);
    vecs[11] = mk(0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'hAA, 0);
    // Result for r0: accepted, no write.
    vecs[12] = mk(0, 0, 10, 0, 1, 0, 32'h1234, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h1234, 0);
    // Result for never-allocated r3: written, error goes sticky.
    vecs[13] = mk(0, 0, 3, 0, 0, 0, 0, 1, 3, 32'h3333, 1, 1, 1, 0, 0, 3, 32'h3333, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 32'h3333, 1);

    rstn = 1'b0;
    drive(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_ard", 32'(ard), 32'd0);
    chk("reset_drd", drd, 32'd0);
    chk("reset_wb_err", 32'(wb_err), 32'd0);
    chk("reset_rs1_busy", 32'(rs1_busy), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].iv, vecs[i].ir, vecs[i].q1, vecs[i].q2, vecs[i].av, vecs[i].ar, vecs[i].ad,
            vecs[i].lv, vecs[i].lr, vecs[i].ld);
      tick($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end

    // Holding an allocation of r7 stalls until r7's writeback.
    drive(1, 7, 7, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("hold_c1_iss", 32'(iss_ready), 32'd1);
    tick("hold_c1", 1'b0, nov);
    drive(1, 7, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    #1 chk("hold_c2_iss", 32'(iss_ready), 32'd0);
    tick("hold_c2", 1'b0, nov);
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("hold_c3_iss", 32'(iss_ready), 32'(BYP));
    tick("hold_c3", 1'b0, nov);
    #1 chk("hold_c4_iss", 32'(iss_ready), 32'(!BYP));
    tick("hold_c4", 1'b0, nov);
    drive(0, 0, 0, 0, 1, 7, 32'h78, 0, 0, 0);
    tick("hold_c5", 1'b0, nov);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("hold_c6", 1'b0, nov);

`ifdef WB_BYPASS_EN
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("byp_c1", 1'b0, nov);
    drive(0, 0, 0, 8, 1, 8, 32'h88, 0, 0, 0);
    tick("byp_c2", 1'b0, nov);
    drive(1, 8, 0, 8, 0, 0, 0, 0, 0, 0);
    #1;
    chk("byp_c3_hit", 32'(byp2_hit), 32'd1);
    chk("byp_c3_rs2", 32'(rs2_busy), 32'd0);
    chk("byp_c3_iss", 32'(iss_ready), 32'd1);
    tick("byp_c3", 1'b0, nov);
    drive(0, 0, 0, 8, 0, 0, 0, 0, 0, 0);
    #1 chk("byp_c4_rs2", 32'(rs2_busy), 32'd1);
    tick("byp_c4", 1'b0, nov);
    drive(0, 0, 0, 0, 1, 8, 32'h89, 0, 0, 0);
    tick("byp_c5", 1'b0, nov);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("byp_c6", 1'b0, nov);
`endif

    // Reset mid-stream with handshakes in flight.
    drive(1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("rst_c1", 1'b0, nov);
    drive(1, 21, 0, 0, 1, 20, 32'h55, 0, 0, 0);
    tick("rst_c2", 1'b0, nov);
    rstn = 1'b0;
    drive(1, 22, 20, 21, 0, 0, 0, 1, 21, 32'h66);
    tick("rst_c3", 1'b0, nov);
    rstn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ard", 32'(ard), 32'd0);
    chk("rst_drd", drd, 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    for (int r = 0; r < 64; r++) begin
      q_rs1 = 6'(r);
      #1 chk($sformatf("rst_busy%0d", r), 32'(rs1_busy), 32'd0);
    end
    q_rs1 = 6'd0;
    tick("rst_c4", 1'b0, nov);

    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(199, 0) != 0);
      drive(int'($urandom_range(1, 0)), int'($urandom_range(11, 0)),
            int'($urandom_range(11, 0)), int'($urandom_range(11, 0)),
            int'($urandom_range(99, 0) < 60), pick_rd(), $urandom(),
            int'($urandom_range(99, 0) < 60), pick_rd(), $urandom());
      tick($sformatf("rnd%0d", c), 1'b0, nov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
